// File: rtl/seg_mux_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Holds segment patterns, blank/dash codes, digit count and shadow type.
package seg_mux_driver_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [5:0] POS_OFF = 6'b111111;

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  dp;
    } shadow_t;

endpackage

// File: rtl/seg_mux_driver_seg7_decode.sv
// BCD nibble to seven-segment pattern; non-BCD codes show a dash.
// Ports: bcd [3:0] in, seg [6:0] out as {a,b,c,d,e,f,g}.
module seg7_decode
    import seg_mux_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_mux_driver.sv
// Six-digit multiplexed seven-segment driver with blanking and blink.
// Ports: clk, rst (async high), digits_in/dp_mask_in/load shadow write,
//        blank_lz, blink_en levels; seg_data {a..g,dp}, seg_position (low).
module seg_mux_driver
    import seg_mux_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits_in,
    input  logic        load,
    input  logic [5:0]  dp_mask_in,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [7:0]  seg_data,
    output logic [5:0]  seg_position
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    shadow_t       shadow;
    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blk_cnt;
    logic [2:0]    idx;
    logic          blink_phase;
    logic          gap;
    logic          wrap;

    logic [5:0]    lz;
    logic          run;
    logic [3:0]    cur_nib;
    logic          cur_dp;
    logic [6:0]    cur_seg;
    logic          blanked;
    logic          dark;

    assign wrap = (ref_cnt == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= '{digits: digits_in, dp: dp_mask_in};
        end
    end

    // gap forces one dark output cycle after reset and after each advance,
    // so the old digit never appears at the new position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            gap     <= 1'b1;
        end else if (wrap) begin
            ref_cnt <= '0;
            idx     <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            gap     <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
            gap     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (blk_cnt == BW'(BLINK_DIV - 1)) begin
            blk_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blk_cnt     <= blk_cnt + BW'(1);
        end
    end

    // lz[i]: digits i..5 and their dp bits are all zero.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (shadow.digits[4*i +: 4] == 4'd0)
                        && !shadow.dp[i];
            lz[i] = run;
        end
    end

    assign cur_nib = shadow.digits[{idx, 2'b00} +: 4];
    assign cur_dp  = shadow.dp[idx];
    assign blanked = blank_lz && (idx != 3'd0) && lz[idx];
    assign dark    = gap || (blink_en && !blink_phase) || blanked;

    seg7_decode u_dec (
        .bcd (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_position <= POS_OFF;
            seg_data     <= 8'h00;
        end else if (dark) begin
            seg_position <= POS_OFF;
            seg_data     <= {SEG_BLANK, 1'b0};
        end else begin
            seg_position <= ~(6'd1 << idx);
            seg_data     <= {cur_seg, cur_dp};
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed self-checking bench for seg_mux_driver.
// Table of display vectors plus hand sequences for blink, load and reset.
module tb_seg_mux_driver;

    logic        clk;
    logic        rst;
    logic [23:0] digits_in;
    logic        load;
    logic [5:0]  dp_mask_in;
    logic        blank_lz;
    logic        blink_en;
    logic [7:0]  seg_data;
    logic [5:0]  seg_position;

    int total = 0;
    int bad   = 0;

    seg_mux_driver #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_in    (digits_in),
        .load         (load),
        .dp_mask_in   (dp_mask_in),
        .blank_lz     (blank_lz),
        .blink_en     (blink_en),
        .seg_data     (seg_data),
        .seg_position (seg_position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] digits;
        logic [5:0]  dp;
        logic        blz;
        logic [47:0] exp_seg;
        logic [5:0]  exp_on;
    } vec_t;

    vec_t vecs [6];

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] ep,
                       input logic [7:0] es);
        total++;
        if (seg_position !== ep || seg_data !== es) begin
            bad++;
            $display("FAIL %s: got pos=%b seg=%h, want pos=%b seg=%h",
                     name, seg_position, seg_data, ep, es);
        end
    endtask

    // Reset, then release mid-cycle; next rising edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] ep;
        logic [7:0] es;

        vecs[0] = '{24'h123456, 6'h00, 1'b0, 48'h60DAF266B6BE, 6'b111111};
        vecs[1] = '{24'h000042, 6'h00, 1'b1, 48'h00000000_66DA, 6'b000011};
        vecs[2] = '{24'h000042, 6'h00, 1'b0, 48'hFCFCFCFC66DA, 6'b111111};
        vecs[3] = '{24'h00000A, 6'b000100, 1'b1, 48'h000000FDFC02, 6'b000111};
        vecs[4] = '{24'h9870FF, 6'b100001, 1'b0, 48'hF7FEE0FC0203, 6'b111111};
        vecs[5] = '{24'h000000, 6'h00, 1'b1, 48'h0000000000FC, 6'b000001};

        rst        = 1'b1;
        digits_in  = '0;
        load       = 1'b0;
        dp_mask_in = '0;
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        #2;
        chk("reset_async", 6'b111111, 8'h00);
        adv(2);
        chk("reset_held", 6'b111111, 8'h00);

        // Reset release: dark after edge 1, digit0 "0" after edge 2.
        rst = 1'b0;
        adv(1);
        chk("post_rst_e1", 6'b111111, 8'h00);
        adv(1);
        chk("post_rst_e2", 6'b111110, 8'hFC);

        // Table vectors: load during cycle before edge 1.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            digits_in  = vecs[v].digits;
            dp_mask_in = vecs[v].dp;
            blank_lz   = vecs[v].blz;
            load       = 1'b1;
            adv(1);
            load       = 1'b0;
            // now after edge 1
            for (int i = 0; i < 6; i++) begin
                adv((i == 0) ? 2 : 2);
                // after edge 4i+3: mid-slot of digit i
                es = vecs[v].exp_seg[8*i +: 8];
                ep = vecs[v].exp_on[i] ? ~(6'd1 << i) : 6'b111111;
                chk($sformatf("vec%0d_dig%0d", v, i), ep, es);
                adv(2);
                // after edge 4i+5: anti-ghost gap
                chk($sformatf("vec%0d_gap%0d", v, i), 6'b111111, 8'h00);
            end
        end

        // Blink: dark edges 1..8, active 9..16, dark 17..24.
        blank_lz = 1'b0;
        do_reset();
        blink_en = 1'b1;
        adv(3);
        chk("blink_dark_e3", 6'b111111, 8'h00);
        adv(5);
        chk("blink_dark_e8", 6'b111111, 8'h00);
        adv(2);
        chk("blink_on_e10", 6'b111011, 8'hFC);
        adv(6);
        chk("blink_on_e16", 6'b110111, 8'hFC);
        adv(2);
        chk("blink_dark_e18", 6'b111111, 8'h00);
        blink_en = 1'b0;
        adv(1);
        chk("blink_off_e19", 6'b101111, 8'hFC);

        // Load on the wrap cycle (edge 4), then a mid-slot load.
        do_reset();
        adv(3);
        chk("wrap_d0_e3", 6'b111110, 8'hFC);
        digits_in = 24'h000050;
        load      = 1'b1;
        adv(1);
        load      = 1'b0;
        chk("wrap_d0_e4", 6'b111110, 8'hFC);
        adv(1);
        chk("wrap_gap_e5", 6'b111111, 8'h00);
        adv(1);
        chk("wrap_new_e6", 6'b111101, 8'hB6);
        digits_in = 24'h000070;
        load      = 1'b1;
        adv(1);
        load      = 1'b0;
        chk("mid_old_e7", 6'b111101, 8'hB6);
        adv(1);
        chk("mid_new_e8", 6'b111101, 8'hE0);

        // Reset mid-slot: dark before next edge, shadow cleared.
        adv(1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_async", 6'b111111, 8'h00);
        adv(1);
        rst = 1'b0;
        adv(1);
        chk("rerst_e1", 6'b111111, 8'h00);
        adv(1);
        chk("rerst_e2", 6'b111110, 8'hFC);
        adv(5);
        chk("rerst_d1_e7", 6'b111101, 8'hFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
